// File: rtl/serial_parallel_if.sv
// rtl/serial_parallel_if.sv - serial link receive side bundle: bit stream in, word handshake out
interface serial_parallel_if #(
   parameter int WIDTH = 4
);
   localparam int CNT_W = $clog2(WIDTH);

   logic             clear;
   logic             shift;
   logic             serial_in;
   logic             ack;
   logic [WIDTH-1:0] data_out;
   logic             data_valid;
   logic             overrun;
   logic             busy;
   logic [CNT_W-1:0] bit_count;

   // Link/consumer side: drives strobes and ack, observes the rebuilt word.
   modport master (
      output clear, shift, serial_in, ack,
      input  data_out, data_valid, overrun, busy, bit_count
   );

   // Receiver side.
   modport slave (
      input  clear, shift, serial_in, ack,
      output data_out, data_valid, overrun, busy, bit_count
   );
endinterface

// File: rtl/serial_parallel.sv
// rtl/serial_parallel.sv - MSB-first serial to parallel receiver with sticky valid/ack and overrun
module serial_parallel #(
   parameter int WIDTH = 4
) (
   input logic              clk,
   input logic              stp_reset_n,
   serial_parallel_if.slave bus
);
   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
   localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

   typedef enum logic {
      IDLE = 1'b0,
      RECV = 1'b1
   } state_t;

   state_t           state_q,  state_d;
   logic [CNT_W-1:0] cnt_q,    cnt_d;
   logic [WIDTH-1:0] sreg_q,   sreg_d;
   logic [WIDTH-1:0] dout_q,   dout_d;
   logic             valid_q,  valid_d;
   logic             ovr_q,    ovr_d;

   logic [WIDTH-1:0] shifted;
   logic             complete;

   // The word being shifted in; also the full word on the completing edge.
   assign shifted  = {sreg_q[WIDTH-2:0], bus.serial_in};
   assign complete = bus.shift && (state_q == RECV) && (cnt_q == LAST_BIT);

   // Next-state: frame FSM, bit counter, word capture and handshake; clear wins over everything.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      sreg_d  = sreg_q;
      dout_d  = dout_q;
      valid_d = valid_q;
      ovr_d   = ovr_q;

      if (bus.clear) begin
         state_d = IDLE;
         cnt_d   = '0;
         sreg_d  = '0;
         valid_d = 1'b0;
         ovr_d   = 1'b0;
      end else begin
         if (bus.shift) begin
            sreg_d = shifted;
            case (state_q)
               IDLE: begin
                  state_d = RECV;
                  cnt_d   = ONE;
               end
               RECV: begin
                  if (cnt_q == LAST_BIT) begin
                     state_d = IDLE;
                     cnt_d   = '0;
                  end else begin
                     cnt_d = cnt_q + ONE;
                  end
               end
               default: begin
                  state_d = IDLE;
                  cnt_d   = '0;
               end
            endcase
         end

         if (complete) begin
            // An ack on the completing edge consumes the old word, so no overrun.
            dout_d  = shifted;
            valid_d = 1'b1;
            if (valid_q && !bus.ack) begin
               ovr_d = 1'b1;
            end
         end else if (bus.ack) begin
            valid_d = 1'b0;
         end
      end
   end

   // State register; an async reset discards any partial word.
   always_ff @(posedge clk or negedge stp_reset_n) begin
      if (!stp_reset_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         sreg_q  <= '0;
         dout_q  <= '0;
         valid_q <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sreg_q  <= sreg_d;
         dout_q  <= dout_d;
         valid_q <= valid_d;
         ovr_q   <= ovr_d;
      end
   end

   assign bus.data_out   = dout_q;
   assign bus.data_valid = valid_q;
   assign bus.overrun    = ovr_q;
   assign bus.busy       = (state_q == RECV);
   assign bus.bit_count  = cnt_q;
endmodule

// File: tb/tb_serial_parallel.sv
// tb/tb_serial_parallel.sv - scoreboard bench for serial_parallel against a bit-queue reference model
module tb_serial_parallel;
   localparam int W = 4;

   typedef struct {
      logic [W-1:0] dout;
      bit           valid;
      bit           ovr;
      bit           busy;
      int           cnt;
   } snap_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   serial_parallel_if #(.WIDTH(W)) bus_if ();

   serial_parallel #(.WIDTH(W)) dut (
      .clk         (clk),
      .stp_reset_n (rst_n),
      .bus         (bus_if)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   snap_t        exp_q[$];
   bit           m_bits[$];
   logic [W-1:0] m_word;
   bit           m_valid;
   bit           m_ovr;

   task automatic chk(string name, int got, int exp);
      checks++;
      if (got != exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_bits.delete();
      m_word  = '0;
      m_valid = 1'b0;
      m_ovr   = 1'b0;
   endtask

   // One clock of stimulus; the model's view of the outputs after the coming edge goes to the scoreboard.
   task automatic cycle(bit sh, bit b, bit ak, bit clr);
      snap_t        s;
      logic [W-1:0] w;
      bit           done;
      @(negedge clk);
      bus_if.shift     = sh;
      bus_if.serial_in = b;
      bus_if.ack       = ak;
      bus_if.clear     = clr;
      done = 1'b0;
      w    = '0;
      if (clr) begin
         m_bits.delete();
         m_valid = 1'b0;
         m_ovr   = 1'b0;
      end else begin
         if (sh) begin
            m_bits.push_back(b);
            if (m_bits.size() == W) begin
               foreach (m_bits[i]) w = {w[W-2:0], m_bits[i]};
               m_bits.delete();
               done = 1'b1;
            end
         end
         if (done) begin
            if (m_valid && !ak) m_ovr = 1'b1;
            m_valid = 1'b1;
            m_word  = w;
         end else if (ak) begin
            m_valid = 1'b0;
         end
      end
      s.dout  = m_word;
      s.valid = m_valid;
      s.ovr   = m_ovr;
      s.busy  = (m_bits.size() != 0);
      s.cnt   = m_bits.size();
      exp_q.push_back(s);
   endtask

   task automatic send_word(logic [W-1:0] w, bit ack_last);
      logic [W-1:0] t;
      t = w;
      for (int i = W - 1; i >= 0; i--) begin
         cycle(1'b1, t[i], (i == 0) ? ack_last : 1'b0, 1'b0);
      end
   endtask

   task automatic check_zero(string tag);
      chk({tag, "_data_out"},   int'(bus_if.data_out),   0);
      chk({tag, "_data_valid"}, int'(bus_if.data_valid), 0);
      chk({tag, "_overrun"},    int'(bus_if.overrun),    0);
      chk({tag, "_busy"},       int'(bus_if.busy),       0);
      chk({tag, "_bit_count"},  int'(bus_if.bit_count),  0);
   endtask

   // Reset asserted between edges: outputs must drop without waiting for a clock.
   task automatic async_reset();
      @(negedge clk);
      bus_if.shift = 1'b0;
      bus_if.ack   = 1'b0;
      bus_if.clear = 1'b0;
      #2 rst_n = 1'b0;
      #1 check_zero("async_reset");
      exp_q.delete();
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Monitor: registered outputs are presented every cycle; compare each against the scoreboard.
   initial begin : monitor
      snap_t s;
      forever begin
         @(posedge clk);
         #1;
         if (rst_n && exp_q.size() > 0) begin
            s = exp_q.pop_front();
            chk("data_out",   int'(bus_if.data_out),   int'(s.dout));
            chk("data_valid", int'(bus_if.data_valid), int'(s.valid));
            chk("overrun",    int'(bus_if.overrun),    int'(s.ovr));
            chk("busy",       int'(bus_if.busy),       int'(s.busy));
            chk("bit_count",  int'(bus_if.bit_count),  s.cnt);
         end
      end
   end

   initial begin : stimulus
      bus_if.shift     = 1'b0;
      bus_if.serial_in = 1'b0;
      bus_if.ack       = 1'b0;
      bus_if.clear     = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      check_zero("reset");
      rst_n = 1'b1;

      // T1: reset mid-word at bit_count=2, then 4'hB
      cycle(1, 1, 0, 0);
      cycle(1, 0, 0, 0);
      async_reset();
      send_word(4'hB, 1'b0);
      cycle(0, 0, 1, 0);

      // T2, T3: 4'hA then ack
      send_word(4'hA, 1'b0);
      cycle(0, 0, 0, 0);
      cycle(0, 0, 1, 0);
      cycle(0, 0, 0, 0);

      // T4: back-to-back 4'h3, 4'hC with ack on the completing edge
      send_word(4'h3, 1'b0);
      send_word(4'hC, 1'b1);
      cycle(0, 0, 1, 0);

      // T5: overrun 4'h5 then 4'h9, then ack leaves overrun set
      send_word(4'h5, 1'b0);
      send_word(4'h9, 1'b0);
      cycle(0, 0, 1, 0);
      cycle(0, 0, 0, 0);

      // T6: clear with shift at bit_count=2, then 4'h6
      cycle(1, 0, 0, 0);
      cycle(1, 1, 0, 0);
      cycle(1, 1, 1, 1);
      send_word(4'h6, 1'b0);
      cycle(0, 0, 0, 0);

      // Random traffic
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 599) == 0) begin
            async_reset();
         end else begin
            cycle(($urandom_range(0, 9) < 7), $urandom_range(0, 1),
                  ($urandom_range(0, 9) < 3), ($urandom_range(0, 99) < 3));
         end
      end

      cycle(0, 0, 0, 0);
      repeat (2) @(negedge clk);
      chk("scoreboard_drained", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
